// File: rtl/intersection_pkg.sv
// Shared types and defaults for the intersection phase scheduler.
package intersection_pkg;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    REQ_NS  = 2'd0,
    REQ_EW  = 2'd1,
    REQ_PED = 2'd2
  } req_id_e;

  localparam int unsigned DEF_MIN_GREEN   = 4;
  localparam int unsigned DEF_MAX_GREEN   = 12;
  localparam int unsigned DEF_YELLOW_TIME = 2;
  localparam int unsigned DEF_ALLRED_TIME = 1;
  localparam int unsigned DEF_WALK_TIME   = 5;
  localparam int unsigned DEF_TIMER_W     = 5;

  // Round-robin grant starting after the last-served requester; NS is the rest phase.
  function automatic phase_e grant_phase(input req_id_e last_id, input logic ns,
                                         input logic ew, input logic ped);
    phase_e g;
    g = NS_GREEN;
    case (last_id)
      REQ_NS: begin
        if (ew)       g = EW_GREEN;
        else if (ped) g = PED_WALK;
        else          g = NS_GREEN;
      end
      REQ_EW: begin
        if (ped)      g = PED_WALK;
        else if (ns)  g = NS_GREEN;
        else if (ew)  g = EW_GREEN;
        else          g = NS_GREEN;
      end
      default: begin
        if (ns)       g = NS_GREEN;
        else if (ew)  g = EW_GREEN;
        else if (ped) g = PED_WALK;
        else          g = NS_GREEN;
      end
    endcase
    return g;
  endfunction

  // Requester that owns a granted phase.
  function automatic req_id_e owner_of(input phase_e ph);
    req_id_e r;
    case (ph)
      EW_GREEN: r = REQ_EW;
      PED_WALK: r = REQ_PED;
      default:  r = REQ_NS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: clears on state entry, counts up, saturates.
module phase_timer #(
  parameter int unsigned TIMER_W = 5,
  parameter int unsigned SAT_VAL = 11
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic [TIMER_W-1:0] duration,
  output logic [TIMER_W-1:0] count,
  output logic               done
);

  localparam logic [TIMER_W-1:0] SAT = TIMER_W'(SAT_VAL);

  // Count register with synchronous clear and saturation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)          count <= '0;
    else if (clear)        count <= '0;
    else if (count != SAT) count <= count + TIMER_W'(1);
  end

  // A state of length D ends on the cycle the count reaches D-1.
  always_comb begin
    done = (count == (duration - TIMER_W'(1)));
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road plus pedestrian phase scheduler with round-robin right-of-way.
module intersection_scheduler
  import intersection_pkg::*;
#(
  parameter int unsigned MIN_GREEN   = DEF_MIN_GREEN,
  parameter int unsigned MAX_GREEN   = DEF_MAX_GREEN,
  parameter int unsigned YELLOW_TIME = DEF_YELLOW_TIME,
  parameter int unsigned ALLRED_TIME = DEF_ALLRED_TIME,
  parameter int unsigned WALK_TIME   = DEF_WALK_TIME,
  parameter int unsigned TIMER_W     = DEF_TIMER_W
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [TIMER_W-1:0] MIN_LAST = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAX_LAST = TIMER_W'(MAX_GREEN - 1);

  phase_e             state, next_state;
  req_id_e            last, next_last;
  logic [TIMER_W-1:0] timer, duration;
  logic               timer_done, timer_clear, green_ready, enter_walk;

  assign timer_clear = (next_state != state);
  assign green_ready = (timer >= MIN_LAST) || (timer >= MAX_LAST);
  assign enter_walk  = (state == ALL_RED) && (next_state == PED_WALK);
  assign phase       = state;

  phase_timer #(
    .TIMER_W (TIMER_W),
    .SAT_VAL (MAX_GREEN - 1)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .duration (duration),
    .count    (timer),
    .done     (timer_done)
  );

  // State and last-granted registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ALL_RED;
      last  <= REQ_PED;
    end else begin
      state <= next_state;
      last  <= next_last;
    end
  end

  // Pedestrian call latch; a new press in the walk-entry cycle survives the clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ped_pending <= 1'b0;
    else          ped_pending <= ped_req | (ped_pending & ~enter_walk);
  end

  // Next-state, grant and per-state duration selection.
  always_comb begin
    next_state = state;
    next_last  = last;
    duration   = '0;
    case (state)
      ALL_RED: begin
        duration = TIMER_W'(ALLRED_TIME);
        if (timer_done) begin
          next_state = grant_phase(last, car_ns, car_ew, ped_pending);
          next_last  = owner_of(next_state);
        end
      end
      NS_GREEN: begin
        if ((car_ew || ped_pending) && green_ready) next_state = NS_YELLOW;
      end
      NS_YELLOW: begin
        duration = TIMER_W'(YELLOW_TIME);
        if (timer_done) next_state = ALL_RED;
      end
      EW_GREEN: begin
        if ((car_ns || ped_pending) && green_ready) next_state = EW_YELLOW;
      end
      EW_YELLOW: begin
        duration = TIMER_W'(YELLOW_TIME);
        if (timer_done) next_state = ALL_RED;
      end
      PED_WALK: begin
        duration = TIMER_W'(WALK_TIME);
        if (timer_done) next_state = ALL_RED;
      end
      default: next_state = ALL_RED;
    endcase
  end

  // Moore lamp decode: each road red unless in its own green or yellow.
  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    walk      = 1'b0;
    case (state)
      NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
      NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
      EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
      EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
      PED_WALK:  walk = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed-vector bench for intersection_scheduler.
module tb_intersection_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       car_ns, car_ew, ped_req;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
  logic       ped_pending;
  logic [2:0] phase;
  logic [6:0] lamps;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clock = ~clock;

  assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};

  intersection_scheduler #(
    .MIN_GREEN   (4),
    .MAX_GREEN   (12),
    .YELLOW_TIME (2),
    .ALLRED_TIME (1),
    .WALK_TIME   (5),
    .TIMER_W     (5)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .car_ns      (car_ns),
    .car_ew      (car_ew),
    .ped_req     (ped_req),
    .ns_red      (ns_red),
    .ns_yellow   (ns_yellow),
    .ns_green    (ns_green),
    .ew_red      (ew_red),
    .ew_yellow   (ew_yellow),
    .ew_green    (ew_green),
    .walk        (walk),
    .ped_pending (ped_pending),
    .phase       (phase)
  );

  // Expected lamps {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk} for a phase code.
  function automatic logic [6:0] lamps_for(input int ph);
    case (ph)
      1:       return 7'b001_100_0;
      2:       return 7'b010_100_0;
      3:       return 7'b100_001_0;
      4:       return 7'b100_010_0;
      5:       return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    car_ns  = 1'b0;
    car_ew  = 1'b0;
    ped_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    car_ns  = 1'b1;
    car_ew  = 1'b1;
    ped_req = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({phase, lamps, ped_pending} !== {3'd0, 7'b100_100_0, 1'b0})
      $display("FAIL reset: phase=%0d lamps=%b pend=%b, expected phase=0 lamps=1001000 pend=0",
               phase, lamps, ped_pending);
    else passed++;
  endtask

  // NS alone rests in green forever; a late EW request ends it at once (timer saturated).
  task automatic test_ns_hold();
    car_ns  = 1'b1;
    car_ew  = 1'b0;
    ped_req = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if ({phase, lamps} !== {3'd1, lamps_for(1)})
        $display("FAIL ns_hold step %0d: phase=%0d lamps=%b, expected phase=1 lamps=%b",
                 i, phase, lamps, lamps_for(1));
      else passed++;
    end
    car_ew = 1'b1;
    tick();
    total++;
    if ({phase, lamps} !== {3'd2, lamps_for(2)})
      $display("FAIL ns_hold_exit: phase=%0d lamps=%b, expected phase=2 lamps=%b",
               phase, lamps, lamps_for(2));
    else passed++;
  endtask

  // EW arrives at timer=1, then both roads keep asking: 4-cycle greens alternate.
  task automatic test_back_to_back();
    int exp [0:21] = '{1,1,1,1,2,2,0,3,3,3,3,4,4,0,1,1,1,1,2,2,0,3};
    do_reset();
    car_ns = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i == 2) car_ew = 1'b1;
      tick();
      total++;
      if ({phase, lamps} !== {3'(exp[i]), lamps_for(exp[i])})
        $display("FAIL back_to_back step %0d: phase=%0d lamps=%b, expected phase=%0d lamps=%b",
                 i, phase, lamps, exp[i], lamps_for(exp[i]));
      else passed++;
    end
  endtask

  // Pedestrian call during EW green is served next, then NS.
  task automatic test_ped();
    int exp  [0:13] = '{3,3,3,3,4,4,0,5,5,5,5,5,0,1};
    int pend [0:13] = '{0,1,1,1,1,1,1,0,0,0,0,0,0,0};
    do_reset();
    car_ew = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 1) begin car_ns = 1'b1; ped_req = 1'b1; end
      if (i == 2) ped_req = 1'b0;
      tick();
      total++;
      if ({phase, lamps, ped_pending} !== {3'(exp[i]), lamps_for(exp[i]), 1'(pend[i])})
        $display("FAIL ped step %0d: phase=%0d lamps=%b pend=%b, expected phase=%0d lamps=%b pend=%0d",
                 i, phase, lamps, ped_pending, exp[i], lamps_for(exp[i]), pend[i]);
      else passed++;
    end
  endtask

  // A press in the walk-entry cycle stays latched and is served in the following round.
  task automatic test_ped_coincide();
    int exp  [0:20] = '{3,3,3,3,4,4,0,5,5,5,5,5,0,1,1,1,1,2,2,0,5};
    int pend [0:20] = '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
    do_reset();
    car_ew = 1'b1;
    for (int i = 0; i < 21; i++) begin
      if (i == 1) begin car_ns = 1'b1; ped_req = 1'b1; end
      if (i == 2) ped_req = 1'b0;
      if (i == 7) ped_req = 1'b1;
      if (i == 8) begin ped_req = 1'b0; car_ew = 1'b0; end
      tick();
      total++;
      if ({phase, lamps, ped_pending} !== {3'(exp[i]), lamps_for(exp[i]), 1'(pend[i])})
        $display("FAIL ped_coincide step %0d: phase=%0d lamps=%b pend=%b, expected phase=%0d lamps=%b pend=%0d",
                 i, phase, lamps, ped_pending, exp[i], lamps_for(exp[i]), pend[i]);
      else passed++;
    end
  endtask

  // Reset asserted between edges during NS yellow takes effect immediately.
  task automatic test_reset_mid_yellow();
    do_reset();
    car_ns = 1'b1;
    tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    repeat (3) tick();
    total++;
    if ({phase, ped_pending} !== {3'd2, 1'b1})
      $display("FAIL pre_reset_yellow: phase=%0d pend=%b, expected phase=2 pend=1",
               phase, ped_pending);
    else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({phase, lamps, ped_pending} !== {3'd0, 7'b100_100_0, 1'b0})
      $display("FAIL async_reset: phase=%0d lamps=%b pend=%b, expected phase=0 lamps=1001000 pend=0",
               phase, lamps, ped_pending);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_ns_hold();
    test_back_to_back();
    test_ped();
    test_ped_coincide();
    test_reset_mid_yellow();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
